// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack unit.
//   op_e          : decoded per-edge command, in priority order
//   SP_RESET_DEF  : default SP after reset (the "empty" mark)
//   SP_LIMIT_DEF  : default highest legal SP (the "full" mark)
//   decode_op     : command priority decode (exchange > push > pop > load > idle)
package stack_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_XCHG,
    OP_PUSH,
    OP_POP,
    OP_LOAD
  } op_e;

  localparam logic [7:0] SP_RESET_DEF = 8'h07;
  localparam logic [7:0] SP_LIMIT_DEF = 8'h7F;

  function automatic op_e decode_op(input logic push, input logic pop, input logic wr_sp);
    if (push && pop) return OP_XCHG;
    if (push)        return OP_PUSH;
    if (pop)         return OP_POP;
    if (wr_sp)       return OP_LOAD;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Control-unit <-> stack unit bundle.
//   master : CPU control side (drives commands, observes SP/data/status)
//   slave  : stack unit side
// Commands: push, pop, push_data, wr_sp, data_in_sp, rd_sp, clr_flags.
// Results : data_out_sp, sp_out, pop_data, pop_valid, full, empty, ovf, udf.
interface stack_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SP_W   = 8
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              wr_sp;
  logic [SP_W-1:0]   data_in_sp;
  logic              rd_sp;
  logic              clr_flags;
  logic [SP_W-1:0]   data_out_sp;
  logic [SP_W-1:0]   sp_out;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              udf;

  modport master (
    output push, pop, push_data, wr_sp, data_in_sp, rd_sp, clr_flags,
    input  data_out_sp, sp_out, pop_data, pop_valid, full, empty, ovf, udf
  );

  modport slave (
    input  push, pop, push_data, wr_sp, data_in_sp, rd_sp, clr_flags,
    output data_out_sp, sp_out, pop_data, pop_valid, full, empty, ovf, udf
  );
endinterface

// File: rtl/stack_ram.sv
// LIFO storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clock : write clock        we    : write enable
//   waddr : write address      wdata : write data
//   raddr : read address       rdata : combinational read data
module stack_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Stack pointer with integrated LIFO storage. Services exchange/push/pop/SP-load in one
// clock, keeps sticky overflow/underflow flags and a registered pop result.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : stack_unit_if.slave (commands in, SP/pop data/status out)
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned     DATA_W   = 8,
  parameter int unsigned     SP_W     = 8,
  parameter logic [SP_W-1:0] SP_RESET = SP_W'(SP_RESET_DEF),
  parameter logic [SP_W-1:0] SP_LIMIT = SP_W'(SP_LIMIT_DEF),
  parameter bit              WRAP_EN  = 1'b1
) (
  input logic         clock,
  input logic         reset,
  stack_unit_if.slave bus
);

  localparam int unsigned DEPTH = int'(SP_LIMIT) + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  op_e               op;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_rdata;

  assign op = decode_op(bus.push, bus.pop, bus.wr_sp);

  always_comb begin
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    // Clear request loses to any flag-setting event below in the same cycle.
    ovf_d       = ovf_q & ~bus.clr_flags;
    udf_d       = udf_q & ~bus.clr_flags;
    ram_we      = 1'b0;
    ram_waddr   = IDX_W'(sp_q);

    unique case (op)
      OP_XCHG: begin
        ram_we      = 1'b1;
        pop_data_d  = ram_rdata;
        pop_valid_d = 1'b1;
      end
      OP_PUSH: begin
        if (sp_q < SP_LIMIT) begin
          sp_d      = sp_q + SP_W'(1);
          ram_we    = 1'b1;
          ram_waddr = IDX_W'(sp_q + SP_W'(1));
        end else begin
          ovf_d = 1'b1;
          if (WRAP_EN) begin
            sp_d      = '0;
            ram_we    = 1'b1;
            ram_waddr = '0;
          end
        end
      end
      OP_POP: begin
        // Without wrap, a pop at the empty mark (or at 0, which would leave the legal
        // range) is rejected outright.
        if (!WRAP_EN && (sp_q == SP_RESET || sp_q == '0)) begin
          udf_d = 1'b1;
        end else begin
          pop_data_d  = ram_rdata;
          pop_valid_d = 1'b1;
          if (sp_q == '0) begin
            sp_d  = SP_LIMIT;
            udf_d = 1'b1;
          end else begin
            sp_d = sp_q - SP_W'(1);
          end
        end
      end
      OP_LOAD: begin
        if (bus.data_in_sp <= SP_LIMIT) sp_d = bus.data_in_sp;
        else                            ovf_d = 1'b1;
      end
      OP_IDLE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q        <= SP_RESET;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  stack_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(bus.push_data),
    .raddr(IDX_W'(sp_q)),
    .rdata(ram_rdata)
  );

  assign bus.data_out_sp = bus.rd_sp ? sp_q : '0;
  assign bus.sp_out      = sp_q;
  assign bus.pop_data    = pop_data_q;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.full        = (sp_q == SP_LIMIT);
  assign bus.empty       = (sp_q == SP_RESET);
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Two stack units (index 0: wrap enabled, index 1: wrap disabled) driven with identical
// commands and checked against an array-based LIFO model.
module tb_stack_unit;

  localparam int RST = 8'h07;
  localparam int LIM = 8'h7F;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stack_unit_if #(.DATA_W(8), .SP_W(8)) bus_w ();
  stack_unit_if #(.DATA_W(8), .SP_W(8)) bus_n ();

  stack_unit #(.DATA_W(8), .SP_W(8), .SP_RESET(8'h07), .SP_LIMIT(8'h7F), .WRAP_EN(1'b1))
    dut_w (.clock(clock), .reset(reset), .bus(bus_w));
  stack_unit #(.DATA_W(8), .SP_W(8), .SP_RESET(8'h07), .SP_LIMIT(8'h7F), .WRAP_EN(1'b0))
    dut_n (.clock(clock), .reset(reset), .bus(bus_n));

  logic [7:0] o_sp [2], o_pd [2], o_dout [2];
  logic       o_pv [2], o_full [2], o_empty [2], o_ovf [2], o_udf [2];

  always_comb begin
    o_sp[0] = bus_w.sp_out;      o_sp[1] = bus_n.sp_out;
    o_pd[0] = bus_w.pop_data;    o_pd[1] = bus_n.pop_data;
    o_dout[0] = bus_w.data_out_sp; o_dout[1] = bus_n.data_out_sp;
    o_pv[0] = bus_w.pop_valid;   o_pv[1] = bus_n.pop_valid;
    o_full[0] = bus_w.full;      o_full[1] = bus_n.full;
    o_empty[0] = bus_w.empty;    o_empty[1] = bus_n.empty;
    o_ovf[0] = bus_w.ovf;        o_ovf[1] = bus_n.ovf;
    o_udf[0] = bus_w.udf;        o_udf[1] = bus_n.udf;
  end

  // Reference model state
  int         m_sp [2];
  logic [7:0] m_mem [2][256];
  bit         m_memk [2][256];
  logic [7:0] m_pd [2];
  bit         m_pdk [2], m_pv [2], m_ovf [2], m_udf [2];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_sp[m] = RST; m_pd[m] = 8'h00; m_pdk[m] = 1'b1;
      m_pv[m] = 1'b0; m_ovf[m] = 1'b0; m_udf[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input bit psh, input bit pp, input logic [7:0] dat,
                            input bit wr, input logic [7:0] din, input bit clr);
    bit wrap = (m == 0);
    int sp = m_sp[m];
    bit fo = 1'b0, fu = 1'b0;
    m_pv[m] = 1'b0;
    if (psh && pp) begin
      m_pd[m] = m_mem[m][sp]; m_pdk[m] = m_memk[m][sp]; m_pv[m] = 1'b1;
      m_mem[m][sp] = dat; m_memk[m][sp] = 1'b1;
    end else if (psh) begin
      if (sp < LIM) begin
        sp = sp + 1; m_mem[m][sp] = dat; m_memk[m][sp] = 1'b1;
      end else begin
        fo = 1'b1;
        if (wrap) begin sp = 0; m_mem[m][0] = dat; m_memk[m][0] = 1'b1; end
      end
    end else if (pp) begin
      if (!wrap && (sp == RST || sp == 0)) fu = 1'b1;
      else begin
        m_pd[m] = m_mem[m][sp]; m_pdk[m] = m_memk[m][sp]; m_pv[m] = 1'b1;
        if (sp == 0) begin sp = LIM; fu = 1'b1; end
        else sp = sp - 1;
      end
    end else if (wr) begin
      if (int'(din) <= LIM) sp = int'(din);
      else fo = 1'b1;
    end
    m_sp[m]  = sp;
    m_ovf[m] = fo | (m_ovf[m] & ~clr);
    m_udf[m] = fu | (m_udf[m] & ~clr);
  endtask

  // Apply one command to both units for one clock edge and advance the model.
  task automatic step(input bit psh, input bit pp, input logic [7:0] dat,
                      input bit wr, input logic [7:0] din, input bit clr);
    bus_w.push = psh; bus_w.pop = pp; bus_w.push_data = dat;
    bus_w.wr_sp = wr; bus_w.data_in_sp = din; bus_w.clr_flags = clr;
    bus_n.push = psh; bus_n.pop = pp; bus_n.push_data = dat;
    bus_n.wr_sp = wr; bus_n.data_in_sp = din; bus_n.clr_flags = clr;
    @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) model_step(m, psh, pp, dat, wr, din, clr);
    bus_w.push = 0; bus_w.pop = 0; bus_w.wr_sp = 0; bus_w.clr_flags = 0;
    bus_n.push = 0; bus_n.pop = 0; bus_n.wr_sp = 0; bus_n.clr_flags = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    bus_w.rd_sp = 1'b1; bus_n.rd_sp = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_dout[m] !== 8'h07 || o_empty[m] !== 1'b1 || o_ovf[m] !== 1'b0 || o_udf[m] !== 1'b0
          || o_pv[m] !== 1'b0 || o_pd[m] !== 8'h00) begin
        errors++;
        $display("FAIL reset_state[%0d]: dout=%h empty=%b ovf=%b udf=%b pv=%b pd=%h want 07 1 0 0 0 00",
                 m, o_dout[m], o_empty[m], o_ovf[m], o_udf[m], o_pv[m], o_pd[m]);
      end
    end
    bus_w.rd_sp = 1'b0; bus_n.rd_sp = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_dout[m] !== 8'h00) begin
        errors++;
        $display("FAIL rd_sp_off[%0d]: dout=%h want 00", m, o_dout[m]);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] vals [3];
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h7E;
    for (int i = 0; i < 3; i++) step(1, 0, vals[i], 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_sp[m] !== 8'h0A || int'(o_sp[m]) != m_sp[m]) begin
        errors++;
        $display("FAIL push3_sp[%0d]: sp=%h want 0a", m, o_sp[m]);
      end
    end
    for (int i = 2; i >= 0; i--) begin
      step(0, 1, 8'h00, 0, 0, 0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (o_pd[m] !== vals[i] || o_pv[m] !== 1'b1 || int'(o_sp[m]) != m_sp[m]) begin
          errors++;
          $display("FAIL pop_order[%0d]: pd=%h pv=%b sp=%h want %h 1 %h",
                   m, o_pd[m], o_pv[m], o_sp[m], vals[i], m_sp[m][7:0]);
        end
      end
    end
    step(0, 0, 8'h00, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_pv[m] !== 1'b0 || o_pd[m] !== 8'hA5 || o_sp[m] !== 8'h07) begin
        errors++;
        $display("FAIL pop_pulse_end[%0d]: pv=%b pd=%h sp=%h want 0 a5 07",
                 m, o_pv[m], o_pd[m], o_sp[m]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_sp [2], exp_pd [2];
    exp_sp[0] = 8'h00; exp_sp[1] = 8'h7F;
    exp_pd[0] = 8'h22; exp_pd[1] = 8'h11;
    step(0, 0, 8'h00, 1, 8'h7E, 1);
    step(1, 0, 8'h11, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_full[m] !== 1'b1 || o_ovf[m] !== 1'b0) begin
        errors++;
        $display("FAIL reach_full[%0d]: full=%b ovf=%b want 1 0", m, o_full[m], o_ovf[m]);
      end
    end
    step(1, 0, 8'h22, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_sp[m] !== exp_sp[m] || o_ovf[m] !== 1'b1 || int'(o_sp[m]) != m_sp[m]) begin
        errors++;
        $display("FAIL push_at_limit[%0d]: sp=%h ovf=%b want %h 1", m, o_sp[m], o_ovf[m], exp_sp[m]);
      end
    end
    step(0, 1, 8'h00, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_pd[m] !== exp_pd[m] || o_pv[m] !== 1'b1 || int'(o_sp[m]) != m_sp[m]
          || o_udf[m] !== m_udf[m]) begin
        errors++;
        $display("FAIL pop_after_ovf[%0d]: pd=%h pv=%b sp=%h udf=%b want %h 1 %h %b",
                 m, o_pd[m], o_pv[m], o_sp[m], o_udf[m], exp_pd[m], m_sp[m][7:0], m_udf[m]);
      end
    end
  endtask

  task automatic test_exchange();
    step(0, 0, 8'h00, 1, 8'h08, 1);
    step(1, 0, 8'h5A, 0, 0, 0);
    step(1, 1, 8'hC3, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_pd[m] !== 8'h5A || o_pv[m] !== 1'b1 || o_sp[m] !== 8'h09) begin
        errors++;
        $display("FAIL exchange[%0d]: pd=%h pv=%b sp=%h want 5a 1 09", m, o_pd[m], o_pv[m], o_sp[m]);
      end
    end
    step(0, 1, 8'h00, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_pd[m] !== 8'hC3 || o_sp[m] !== 8'h08) begin
        errors++;
        $display("FAIL pop_after_xchg[%0d]: pd=%h sp=%h want c3 08", m, o_pd[m], o_sp[m]);
      end
    end
  endtask

  task automatic test_underflow_load();
    do_reset();
    step(0, 1, 8'h00, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (int'(o_sp[m]) != m_sp[m] || o_pv[m] !== m_pv[m] || o_udf[m] !== m_udf[m]) begin
        errors++;
        $display("FAIL pop_at_reset[%0d]: sp=%h pv=%b udf=%b want %h %b %b",
                 m, o_sp[m], o_pv[m], o_udf[m], m_sp[m][7:0], m_pv[m], m_udf[m]);
      end
    end
    checks++;
    if (o_sp[1] !== 8'h07 || o_pv[1] !== 1'b0 || o_udf[1] !== 1'b1) begin
      errors++;
      $display("FAIL reject_pop_nowrap: sp=%h pv=%b udf=%b want 07 0 1", o_sp[1], o_pv[1], o_udf[1]);
    end
    step(0, 0, 8'h00, 0, 0, 1);
    checks++;
    if (o_udf[1] !== 1'b0) begin
      errors++;
      $display("FAIL clr_udf: udf=%b want 0", o_udf[1]);
    end
    // Flag-setting event wins over a simultaneous clear.
    step(0, 1, 8'h00, 0, 0, 1);
    checks++;
    if (o_udf[1] !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_set: udf=%b want 1", o_udf[1]);
    end
    step(0, 0, 8'h00, 1, 8'h90, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (int'(o_sp[m]) != m_sp[m] || o_ovf[m] !== 1'b1) begin
        errors++;
        $display("FAIL bad_load[%0d]: sp=%h ovf=%b want %h 1", m, o_sp[m], o_ovf[m], m_sp[m][7:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 8'h00, 1, 8'hF0, 0);
    step(1, 0, 8'h44, 0, 0, 0);
    step(1, 0, 8'h55, 0, 0, 0);
    step(0, 1, 8'h00, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_sp[m] !== 8'h07 || o_pv[m] !== 1'b0 || o_ovf[m] !== 1'b0 || o_udf[m] !== 1'b0
          || o_pd[m] !== 8'h00) begin
        errors++;
        $display("FAIL async_reset[%0d]: sp=%h pv=%b ovf=%b udf=%b pd=%h want 07 0 0 0 00",
                 m, o_sp[m], o_pv[m], o_ovf[m], o_udf[m], o_pd[m]);
      end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      int r = int'($urandom_range(0, 99));
      logic [7:0] dat = 8'($urandom);
      logic [7:0] din = 8'($urandom_range(0, 8'h9F));
      bit clr = ($urandom_range(0, 9) == 0);
      if (r < 35)      step(1, 0, dat, 0, din, clr);
      else if (r < 65) step(0, 1, dat, 0, din, clr);
      else if (r < 70) step(1, 1, dat, 0, din, clr);
      else if (r < 78) step(0, 0, dat, 1, din, clr);
      else             step(0, 0, dat, 0, din, clr);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (int'(o_sp[m]) != m_sp[m] || o_pv[m] !== m_pv[m] || o_ovf[m] !== m_ovf[m]
            || o_udf[m] !== m_udf[m] || o_full[m] !== (m_sp[m] == LIM)
            || o_empty[m] !== (m_sp[m] == RST) || (m_pdk[m] && o_pd[m] !== m_pd[m])) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: sp=%h pv=%b ovf=%b udf=%b pd=%h want %h %b %b %b %h",
                   m, i, o_sp[m], o_pv[m], o_ovf[m], o_udf[m], o_pd[m],
                   m_sp[m][7:0], m_pv[m], m_ovf[m], m_udf[m], m_pd[m]);
        end
      end
    end
  endtask

  initial begin
    bus_w.push = 0; bus_w.pop = 0; bus_w.push_data = 0; bus_w.wr_sp = 0;
    bus_w.data_in_sp = 0; bus_w.rd_sp = 0; bus_w.clr_flags = 0;
    bus_n.push = 0; bus_n.pop = 0; bus_n.push_data = 0; bus_n.wr_sp = 0;
    bus_n.data_in_sp = 0; bus_n.rd_sp = 0; bus_n.clr_flags = 0;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 256; a++) m_memk[m][a] = 1'b0;
    model_reset();
    test_reset();
    test_push_pop();
    test_overflow();
    test_exchange();
    test_underflow_load();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
